pe_au_ctrl: RTL and testbench
=============================

// Module: pe_au_ctrl
// PURPOSE
//  Sequencer for one PE_AU (DSP48E2 MAC) computing ROWS rows of N-term dot products: row r = sum_j A[j]*B[r].
//  Drives operand-memory read addresses and the per-cycle OPMODE so the PE_AU accumulates each row in its P register.
//  Flags each completed row to the downstream AMNS reduction logic.
//  Sits between the operand coefficient RAMs and PE_AU, which is instantiated with ABREG=0, MREG=0, PREG=1.
// PARAMETERS
//  N      5     products per row (coefficients per operand), >=1
//  ROWS   5     rows per job, >=1
//  AW     $clog2(N)>0 ? $clog2(N) : 1  A-address width (localparam)
//  RW     $clog2(ROWS)>0 ? $clog2(ROWS) : 1  B-address/row-index width (localparam)
// PORTS
//  clock_i      in   1   single clock, rising edge
//  reset_i      in   1   asynchronous, active-high reset
//  start_i      in   1   job request; accepted when start_i & ready_o
//  ready_o      out  1   high in IDLE only
//  a_addr_o     out  AW  A-RAM read address (sync RAM, 1-cycle read latency)
//  b_addr_o     out  RW  B-RAM read address (sync RAM, 1-cycle read latency)
//  OPMODE_o     out  9   to PE_AU OPMODE_i, aligned with RAM data
//  CREG_en_o    out  1   to PE_AU CREG_en_i, 1-cycle pulse to latch C
//  row_valid_o  out  1   P_o holds the finished sum for row row_idx_o
//  row_idx_o    out  RW  index of the row flagged by row_valid_o
//  done_o       out  1   1-cycle pulse with the last row_valid_o
// BEHAVIOUR
//  - Reset values: ready_o=1; a_addr_o=0; b_addr_o=0; OPMODE_o=OP_HOLD; CREG_en_o=0; row_valid_o=0; row_idx_o=0; done_o=0.
//  - OPMODE encodings, fields {W[8:7], Z[6:4], Y[3:2], X[1:0]}:
//    OP_MAC_C=9'b000110101 (P=A*B+C); OP_MAC_P=9'b000100101 (P=A*B+P);
//    OP_MAC_SHR=9'b001100101 (P=A*B+(P>>17)); OP_HOLD=9'b000100000 (P=P).
//  - FSM IDLE -> ISSUE -> DRAIN -> IDLE. All outputs registered.
//  - IDLE: start accepted at cycle s. CREG_en_o=1 at s+1. Goes to ISSUE at s+1.
//  - ISSUE: (i,j) issued at cycle t=s+1+i*N+j, with a_addr_o=j and b_addr_o=i. j wraps N-1 -> 0, then i increments.
//  - OPMODE_o at t+1: OP_MAC_C if j==0, else OP_MAC_P. The result appears in P at t+2.
//  - Issue of (ROWS-1,N-1) moves the FSM to DRAIN.
//  - DRAIN: lasts 2 cycles. OPMODE_o=OP_HOLD except the cycle carrying the final issued product.
//  - Row completion: row_valid_o=1 and row_idx_o=i at cycle s+2+(i+1)*N, one cycle per row.
//    Generated by a 2-stage tag pipeline {last_of_row, i}.
//  - done_o is asserted in the same cycle as the row_valid_o for i=ROWS-1. ready_o=1 in the next cycle.
//    Total job latency: done_o at s+2+ROWS*N.
//  - Back-to-back jobs: a start accepted on the first ready_o cycle issues its first address one cycle later.
//  - start_i while busy is ignored: no queueing, no effect.
//  - N=1: every product is both first and last of its row, so row_valid_o is high on ROWS consecutive cycles.
//  - reset_i mid-job: immediate return to reset values; the job is discarded and tags are flushed.
//    P contents in the PE_AU are don't-care.
//  - OPMODE_o stays OP_HOLD in IDLE, so P_o is stable after done_o.
// CONFIGURATION
//  PE_AU_CTRL_SHIFT_EN defined:
//    row 0, j=0 uses OP_MAC_C; rows i>=1, j=0 use OP_MAC_SHR.
//    The carry (P>>17) of row i-1 is folded into row i. CREG_en_o still pulses once per job.
//  PE_AU_CTRL_SHIFT_EN undefined:
//    every row starts with OP_MAC_C, so rows are independent (each row = sum + C).
// STRUCTURE
//  Package pe_au_ctrl_pkg: OP_MAC_C/OP_MAC_P/OP_MAC_SHR/OP_HOLD localparams; state_t enum {IDLE, ISSUE, DRAIN};
//    SHIFT_W=17.
//  Sub-module pe_au_ctrl_tag_pipe: 2-deep delay line of {valid, last_of_row, last_row, row_idx}, async reset.
//    Produces row_valid_o, row_idx_o, done_o.
//  Top: FSM, j/i counters, 1-cycle OPMODE alignment register.
// TESTING  (real PE_AU + behavioural sync RAMs; N=5, ROWS=5, C_i=0, A[j]=2^17, B[i]=1)
//  1. Nominal, macro off: start at s -> row_valid_o at s+7, s+12, s+17, s+22, s+27.
//     P_o=655360 on each; done_o at s+27.
//  2. Nominal, PE_AU_CTRL_SHIFT_EN on: same timing.
//     P_o rows = 655360, 655365, 655365, 655365, 655365.
//  3. start_i held high throughout -> the second job starts exactly when ready_o rises.
//     No start is lost; none is double-accepted.
//  4. start_i pulsed during ISSUE -> ignored; a single done_o; OPMODE_o sequence unchanged.
//  5. reset_i asserted at s+9 (mid row 1) -> same cycle: ready_o=1, row_valid_o=0, OPMODE_o=OP_HOLD.
//     A new start completes normally.
//  6. N=1, ROWS=3, A[0]=3, B={1,2,3} -> row_valid_o at s+3, s+4, s+5.
//     P_o=3, 6, 9 with macro off; done_o at s+5.

Source files
------------

// File: rtl/pe_au_ctrl_pkg.sv
// Shared encodings for the PE_AU sequencer: DSP48E2 OPMODE words and FSM states.
package pe_au_ctrl_pkg;

    // OPMODE fields are {W[8:7], Z[6:4], Y[3:2], X[1:0]}
    localparam logic [8:0] OP_MAC_C   = 9'b000110101;  // P = A*B + C
    localparam logic [8:0] OP_MAC_P   = 9'b000100101;  // P = A*B + P
    localparam logic [8:0] OP_MAC_SHR = 9'b001100101;  // P = A*B + (P >> SHIFT_W)
    localparam logic [8:0] OP_HOLD    = 9'b000100000;  // P = P

    localparam int SHIFT_W = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pe_au_ctrl_tag_pipe.sv
// Two-stage delay line carrying per-product row tags so row_valid/done line up
// with the P register of the PE_AU (RAM read + PREG = 2 cycles after issue).
module pe_au_ctrl_tag_pipe #(
    parameter int RW = 3
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          tag_valid,
    input  logic          tag_last_of_row,
    input  logic          tag_last_row,
    input  logic [RW-1:0] tag_row,
    output logic          row_valid,
    output logic [RW-1:0] row_idx,
    output logic          done
);

    localparam int STAGES = 2;

    // Only the last product of a row produces a flag, so qualify on entry.
    logic                     vld_in;
    logic                     done_in;
    logic [STAGES:1]          vld_pipe;
    logic [STAGES:1]          done_pipe;
    logic [STAGES:1][RW-1:0]  row_pipe;

    assign vld_in  = tag_valid & tag_last_of_row;
    assign done_in = vld_in & tag_last_row;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            vld_pipe  <= '0;
            done_pipe <= '0;
            row_pipe  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], vld_in};
            done_pipe <= {done_pipe[STAGES-1:1], done_in};
            row_pipe  <= {row_pipe[STAGES-1:1], tag_row};
        end
    end

    assign row_valid = vld_pipe[STAGES];
    assign done      = done_pipe[STAGES];
    assign row_idx   = row_pipe[STAGES];

endmodule

// File: rtl/pe_au_ctrl.sv
// Sequencer for one PE_AU MAC computing ROWS rows of N-term dot products.
// Build option: define PE_AU_CTRL_SHIFT_EN to fold (P>>17) of row i-1 into row i.
module pe_au_ctrl
    import pe_au_ctrl_pkg::*;
#(
    parameter  int N    = 5,
    parameter  int ROWS = 5,
    localparam int AW   = ($clog2(N) > 0) ? $clog2(N) : 1,
    localparam int RW   = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          ready_o,
    output logic [AW-1:0] a_addr_o,
    output logic [RW-1:0] b_addr_o,
    output logic [8:0]    OPMODE_o,
    output logic          CREG_en_o,
    output logic          row_valid_o,
    output logic [RW-1:0] row_idx_o,
    output logic          done_o
);

    localparam logic [AW-1:0] J_LAST = AW'(N - 1);
    localparam logic [RW-1:0] I_LAST = RW'(ROWS - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] j;
    logic [RW-1:0] i;
    logic          drain_cnt;
    logic          issuing;
    logic          row_end;
    logic          last_row;
    logic          accept;
    logic [8:0]    row_op;
    logic [8:0]    op_nxt;

    assign issuing  = (state == ISSUE);
    assign row_end  = (j == J_LAST);
    assign last_row = (i == I_LAST);
    assign accept   = (state == IDLE) && start_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = ISSUE;
            ISSUE:   if (row_end && last_row) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PE_AU_CTRL_SHIFT_EN
    assign row_op = (i == '0) ? OP_MAC_C : OP_MAC_SHR;
`else
    assign row_op = OP_MAC_C;
`endif

    // Computed in the issue cycle, registered so it meets the RAM data one cycle later.
    always_comb begin
        op_nxt = OP_HOLD;
        if (issuing) op_nxt = (j == '0) ? row_op : OP_MAC_P;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            j         <= '0;
            i         <= '0;
            drain_cnt <= 1'b0;
            OPMODE_o  <= OP_HOLD;
            CREG_en_o <= 1'b0;
            ready_o   <= 1'b1;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            OPMODE_o  <= op_nxt;
            CREG_en_o <= accept;
            ready_o   <= (state_nxt == IDLE);
            // Counters wrap to zero on the final issue, so IDLE always presents address 0.
            if (issuing) begin
                j <= row_end ? '0 : j + AW'(1);
                if (row_end) i <= last_row ? '0 : i + RW'(1);
            end
        end
    end

    assign a_addr_o = j;
    assign b_addr_o = i;

    pe_au_ctrl_tag_pipe #(.RW(RW)) u_tag_pipe (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .tag_valid       (issuing),
        .tag_last_of_row (row_end),
        .tag_last_row    (last_row),
        .tag_row         (i),
        .row_valid       (row_valid_o),
        .row_idx         (row_idx_o),
        .done            (done_o)
    );

endmodule

// File: tb/tb_pe_au_ctrl.sv
// Scoreboard bench for pe_au_ctrl: two instances (N=5/ROWS=5 and N=1/ROWS=3) each
// driving a behavioural PE_AU plus sync RAMs; row flags and P values are checked.
`timescale 1ns/1ps
module tb_pe_au_ctrl;

    localparam logic [8:0] T_MAC_C   = 9'b000110101;
    localparam logic [8:0] T_MAC_P   = 9'b000100101;
    localparam logic [8:0] T_MAC_SHR = 9'b001100101;
    localparam logic [8:0] T_HOLD    = 9'b000100000;

`ifdef PE_AU_CTRL_SHIFT_EN
    localparam logic [63:0] EXP5 [5] = '{64'd655360, 64'd655365, 64'd655365, 64'd655365, 64'd655365};
`else
    localparam logic [63:0] EXP5 [5] = '{64'd655360, 64'd655360, 64'd655360, 64'd655360, 64'd655360};
`endif
    localparam logic [63:0] EXP1 [3] = '{64'd3, 64'd6, 64'd9};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        int          cyc;
        int          idx;
        logic        done;
        logic [63:0] p;
    } exp_t;
    exp_t sb[$];
    int   acc0_q[$];
    int   acc1_q[$];
    int   done0_cnt = 0;

    // instance 0: N=5, ROWS=5
    logic       start0 = 1'b0, ready0, creg0, rv0, done0;
    logic [2:0] aa0, ba0, ri0;
    logic [8:0] op0;
    // instance 1: N=1, ROWS=3
    logic       start1 = 1'b0, ready1, creg1, rv1, done1;
    logic [0:0] aa1;
    logic [1:0] ba1, ri1;
    logic [8:0] op1;

    pe_au_ctrl #(.N(5), .ROWS(5)) u_dut0 (
        .clock_i(clk), .reset_i(rst), .start_i(start0), .ready_o(ready0),
        .a_addr_o(aa0), .b_addr_o(ba0), .OPMODE_o(op0), .CREG_en_o(creg0),
        .row_valid_o(rv0), .row_idx_o(ri0), .done_o(done0)
    );

    pe_au_ctrl #(.N(1), .ROWS(3)) u_dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start1), .ready_o(ready1),
        .a_addr_o(aa1), .b_addr_o(ba1), .OPMODE_o(op1), .CREG_en_o(creg1),
        .row_valid_o(rv1), .row_idx_o(ri1), .done_o(done1)
    );

    // Behavioural PE_AU (ABREG=0, MREG=0, PREG=1) fed by sync RAMs, C_i = 0.
    function automatic logic [47:0] mac(input logic [8:0] op, input logic [47:0] m,
                                        input logic [47:0] c, input logic [47:0] p);
        case (op)
            T_MAC_C:   return m + c;
            T_MAC_P:   return m + p;
            T_MAC_SHR: return m + (p >> 17);
            default:   return p;
        endcase
    endfunction

    logic [47:0] a0_mem [8];
    logic [47:0] b0_mem [8];
    logic [47:0] a1_mem [2];
    logic [47:0] b1_mem [4];
    logic [47:0] ra0, rb0, c0 = '0, p0 = '0;
    logic [47:0] ra1, rb1, c1 = '0, p1 = '0;

    always @(posedge clk) begin
        ra0 <= a0_mem[aa0];
        rb0 <= b0_mem[ba0];
        if (creg0) c0 <= 48'd0;
        p0  <= mac(op0, ra0 * rb0, c0, p0);
        ra1 <= a1_mem[aa1];
        rb1 <= b1_mem[ba1];
        if (creg1) c1 <= 48'd0;
        p1  <= mac(op1, ra1 * rb1, c1, p1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected row flags are pushed when a start is accepted (cycle s = current cyc).
    always @(posedge clk) begin
        if (!rst && start0 && ready0) begin
            acc0_q.push_back(cyc);
            for (int r = 0; r < 5; r++)
                sb.push_back('{0, cyc + 2 + (r + 1) * 5, r, (r == 4), EXP5[r]});
        end
        if (!rst && start1 && ready1) begin
            acc1_q.push_back(cyc);
            for (int r = 0; r < 3; r++)
                sb.push_back('{1, cyc + 2 + (r + 1), r, (r == 2), EXP1[r]});
        end
    end

    task automatic check_row(input int d, input int idx, input logic dn, input logic [47:0] p);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_row", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("row_dut", d, e.dut);
        chk("row_cycle", cyc, e.cyc);
        chk("row_idx", idx, e.idx);
        chk("row_done", dn, e.done);
        chk("row_P", {16'd0, p}, e.p);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done0) done0_cnt++;
            if (done0 && !rv0) chk("done0_without_row", 1, 0);
            if (done1 && !rv1) chk("done1_without_row", 1, 0);
            if (rv0) check_row(0, int'(ri0), done0, p0);
            if (rv1) check_row(1, int'(ri1), done1, p1);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missing_row", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && ready0 && ready1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int s, base, dbase;
        for (int k = 0; k < 8; k++) begin a0_mem[k] = 48'd131072; b0_mem[k] = 48'd1; end
        a1_mem[0] = 48'd3; a1_mem[1] = 48'd0;
        b1_mem[0] = 48'd1; b1_mem[1] = 48'd2; b1_mem[2] = 48'd3; b1_mem[3] = 48'd0;

        // reset values
        #12;
        chk("rst_ready", ready0, 1);
        chk("rst_a_addr", aa0, 0);
        chk("rst_b_addr", ba0, 0);
        chk("rst_opmode", op0, T_HOLD);
        chk("rst_creg", creg0, 0);
        chk("rst_row_valid", rv0, 0);
        chk("rst_row_idx", ri0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ready1", ready1, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // nominal job plus first-cycle alignment
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("s1_creg", creg0, 1);
        chk("s1_ready", ready0, 0);
        chk("s1_a_addr", aa0, 0);
        chk("s1_opmode", op0, T_HOLD);
        @(negedge clk);
        chk("s2_creg", creg0, 0);
        chk("s2_a_addr", aa0, 1);
        chk("s2_opmode", op0, T_MAC_C);
        drain();
        chk("job1_done_count", done0_cnt, 1);

        // start held high: back-to-back without loss or double accept
        base = acc0_q.size();
        start0 = 1'b1;
        for (int k = 0; k < 100 && acc0_q.size() < base + 2; k++) @(negedge clk);
        start0 = 1'b0;
        chk("b2b_accepts", acc0_q.size(), base + 2);
        if (acc0_q.size() >= base + 2)
            chk("b2b_gap", acc0_q[base + 1] - acc0_q[base], 28);
        drain();
        chk("b2b_no_extra", acc0_q.size(), base + 2);

        // start pulsed during ISSUE is ignored
        base  = acc0_q.size();
        dbase = done0_cnt;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain();
        chk("busy_start_accepts", acc0_q.size(), base + 1);
        chk("busy_start_dones", done0_cnt - dbase, 1);

        // reset mid-job
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        s = acc0_q[$];
        while (cyc < s + 9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_ready", ready0, 1);
        chk("midrst_row_valid", rv0, 0);
        chk("midrst_opmode", op0, T_HOLD);
        chk("midrst_a_addr", aa0, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain();

        // N=1 instance
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        drain();
        chk("n1_accepts", acc1_q.size(), 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
